apb4_master: RTL and testbench

APB4_MASTER -- requirements
Module: apb4_master

---
 rtl/apb4_master.sv | 151 +++++++++++++++
 tb/tb_apb4_master.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/apb4_master.sv
// APB4 requester: turns a valid/ready command into one SETUP/ACCESS transfer and returns a held response.
// Optional build macro APB4_MASTER_TIMEOUT_EN adds an ACCESS wait-state timeout of TIMEOUT_CYCLES.
module apb4_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_write,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    input  logic [2:0]              req_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [2:0]              PPROT,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
            $error("apb4_master: TIMEOUT_CYCLES must be in 1..65535");
        end
    endgenerate

    state_t                  r_state;
    logic                    r_req_ready;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_err;
    logic                    r_psel;
    logic                    r_penable;
    logic                    r_pwrite;
    logic [ADDR_WIDTH-1:0]   r_paddr;
    logic [DATA_WIDTH-1:0]   r_pwdata;
    logic [DATA_WIDTH/8-1:0] r_pstrb;
    logic [2:0]              r_pprot;
`ifdef APB4_MASTER_TIMEOUT_EN
    logic [15:0]             r_timeout_cnt;
`endif

    // Every output is a flop with async clear, so PRESET zeroes the outputs without a clock edge.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state       <= S_IDLE;
            r_req_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_pprot       <= '0;
`ifdef APB4_MASTER_TIMEOUT_EN
            r_timeout_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_psel      <= 1'b1;
                        r_penable   <= 1'b0;
                        r_pwrite    <= req_write;
                        r_paddr     <= req_addr;
                        r_pwdata    <= req_write ? req_wdata : '0;
                        r_pstrb     <= req_write ? req_strb : '0;
                        r_pprot     <= req_prot;
                        r_state     <= S_SETUP;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
                        r_rsp_err   <= PSLVERR;
                        r_state     <= S_RESP;
`ifdef APB4_MASTER_TIMEOUT_EN
                        r_timeout_cnt <= '0;
                    end else if (r_timeout_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        // This wait cycle makes TIMEOUT_CYCLES in total: abandon the transfer.
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_timeout_cnt <= '0;
                        r_state       <= S_RESP;
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + 16'd1;
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign PSTRB     = r_pstrb;
    assign PPROT     = r_pprot;

endmodule

// File: tb/tb_apb4_master.sv
// Self-checking bench for apb4_master: directed and randomized transfers against a transaction-level model.
module tb_apb4_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          PRESET;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_write;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_strb;
    logic [2:0]    req_prot;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [SW-1:0] PSTRB;
    logic [2:0]    PPROT;
    logic [DW-1:0] PRDATA;
    logic          PREADY, PSLVERR;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    apb4_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(clk), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One transfer seen from outside: request at cycle 0, SETUP at 1, ACCESS from 2 for waits+1
    // cycles, then the response held for 'hold' cycles before it is consumed.
    task automatic do_txn(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                          input logic [SW-1:0] strb, input logic [2:0] prot, input int waits,
                          input logic slverr, input logic [DW-1:0] rdata, input int hold,
                          input bit timeout);
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        logic [DW-1:0] exp_pwdata;
        logic [SW-1:0] exp_pstrb;
        exp_pwdata = wr ? wdata : '0;
        exp_pstrb  = wr ? strb : '0;
        exp_rdata  = (wr || timeout) ? '0 : rdata;
        exp_err    = timeout ? 1'b1 : slverr;

        req_valid = 1'b1; req_addr = addr; req_write = wr;
        req_wdata = wdata; req_strb = strb; req_prot = prot;
        check("req_ready_idle", req_ready, 1'b1);
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        // Completer noise outside ACCESS must be ignored.
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = $urandom;
        check("setup_psel", PSEL, 1'b1);
        check("setup_penable", PENABLE, 1'b0);
        check("setup_req_ready", req_ready, 1'b0);
        check("setup_paddr", PADDR, addr);
        check("setup_pwrite", PWRITE, wr);
        check("setup_pwdata", PWDATA, exp_pwdata);
        check("setup_pstrb", PSTRB, exp_pstrb);
        check("setup_pprot", PPROT, prot);
        for (int k = 0; k <= waits; k++) begin
            @(posedge clk); @(negedge clk);
            check("access_psel", PSEL, 1'b1);
            check("access_penable", PENABLE, 1'b1);
            check("access_rsp_valid", rsp_valid, 1'b0);
            check("access_paddr", PADDR, addr);
            check("access_pwdata", PWDATA, exp_pwdata);
            check("access_pstrb", PSTRB, exp_pstrb);
            check("access_pprot", PPROT, prot);
            PREADY  = !timeout && (k == waits);
            PSLVERR = (k == waits) ? slverr : 1'($urandom);
            PRDATA  = (k == waits) ? rdata : DW'($urandom);
        end
        @(posedge clk); @(negedge clk);
        PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
        check("resp_valid", rsp_valid, 1'b1);
        check("resp_psel", PSEL, 1'b0);
        check("resp_penable", PENABLE, 1'b0);
        check("resp_rdata", rsp_rdata, exp_rdata);
        check("resp_err", rsp_err, exp_err);
        check("resp_req_ready", req_ready, 1'b0);
        rsp_ready = (hold == 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); @(negedge clk);
            PRDATA = $urandom; PSLVERR = 1'($urandom);
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_rdata", rsp_rdata, exp_rdata);
            check("hold_err", rsp_err, exp_err);
            check("hold_req_ready", req_ready, 1'b0);
            if (h == hold - 1) rsp_ready = 1'b1;
        end
        @(posedge clk); @(negedge clk);
        rsp_ready = 1'b0;
        check("after_rsp_valid", rsp_valid, 1'b0);
        check("after_req_ready", req_ready, 1'b1);
        $display("txn addr=0x%08h wr=%0d waits=%0d hold=%0d to=%0d rdata=0x%08h err=%0d",
                 addr, wr, waits, hold, timeout, exp_rdata, exp_err);
    endtask

    initial begin
        PRESET = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
        req_wdata = '0; req_strb = '0; req_prot = '0; rsp_ready = 1'b0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_psel", PSEL, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_paddr", PADDR, '0);
        @(negedge clk); @(negedge clk);
        PRESET = 1'b0;
        #1 check("rel_req_ready_low", req_ready, 1'b0);
        @(negedge clk);

        // Directed: zero-wait write, 3-wait read, erroring write with a stalled consumer.
        do_txn(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 1'b0, 32'h0, 0, 1'b0);
        do_txn(32'h0000_0020, 1'b0, 32'h0, 4'h0, 3'd2, 3, 1'b0, 32'h1234_5678, 0, 1'b0);
        do_txn(32'h0000_0030, 1'b1, 32'hCAFE_F00D, 4'h5, 3'd1, 1, 1'b1, 32'h0, 5, 1'b0);
        // Back-to-back reads with the response consumed immediately.
        for (int i = 0; i < 3; i++)
            do_txn(32'h100 + 32'(i * 4), 1'b0, $urandom, 4'hF, 3'd0, 0, 1'b0, $urandom, 0, 1'b0);
        for (int i = 0; i < 20; i++)
            do_txn($urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
                   $urandom_range(0, TO - 1), 1'($urandom), $urandom, $urandom_range(0, 2), 1'b0);
`ifdef APB4_MASTER_TIMEOUT_EN
        do_txn(32'h0000_0040, 1'b0, 32'h0, 4'h0, 3'd0, TO - 1, 1'b0, 32'hFFFF_FFFF, 1, 1'b1);
`else
        do_txn(32'h0000_0040, 1'b0, 32'h0, 4'h0, 3'd0, 20, 1'b0, 32'hA5A5_5A5A, 1, 1'b0);
`endif

        // Reset in the middle of ACCESS: outputs drop at once, transfer is lost.
        req_valid = 1'b1; req_addr = 32'h50; req_write = 1'b0; req_prot = 3'd0;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0; PREADY = 1'b0;
        @(posedge clk); @(negedge clk);
        check("pre_rst_penable", PENABLE, 1'b1);
        #2 PRESET = 1'b1;
        #1;
        check("async_rst_psel", PSEL, 1'b0);
        check("async_rst_penable", PENABLE, 1'b0);
        check("async_rst_rsp_valid", rsp_valid, 1'b0);
        check("async_rst_req_ready", req_ready, 1'b0);
        PREADY = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        #2 PRESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_req_ready", req_ready, 1'b1);
            check("post_rst_rsp_valid", rsp_valid, 1'b0);
            check("post_rst_psel", PSEL, 1'b0);
        end
        rsp_ready = 1'b0;
        $display("reset-during-access sequence done");
        do_txn(32'h0000_0060, 1'b1, 32'h0BAD_F00D, 4'h3, 3'd7, 0, 1'b0, 32'h0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
